// File: rtl/ram_port.sv
// ram_port: simple dual-port synchronous RAM with one write port and one
// independent registered read port on a shared clock.
//
// Build option RAM_PORT_BYPASS_EN:
//   undefined - a same-address read-during-write returns the old stored word.
//   defined   - a same-address read-during-write forwards the incoming data
//               (write-through). The array is written normally either way.
//
// aclr clears only the read output register, asynchronously. While aclr is
// high, writes are blocked. The array has no reset. Its zero power-up
// contents come from the device's memory initialisation.
module ram_port #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clock,
   input  logic              aclr,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic              wren,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q
);

   // Every address value must select a real word.
   generate
      if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
         $error("ram_port: DEPTH must equal 2**ADDR_W");
      end
   endgenerate

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_fire;
   logic [DATA_W-1:0] rd_next;

   // A write is accepted only when the clear is inactive.
   assign wr_fire = wren & ~aclr;

`ifdef RAM_PORT_BYPASS_EN
   // Pick the read source. A same-address write this edge forwards the new data.
   always_comb begin
      rd_next = mem[rdaddress];
      if (wren && (wraddress == rdaddress)) begin
         rd_next = data;
      end
   end
`else
   // Pick the read source. The array is read before this edge's write lands.
   always_comb begin
      rd_next = mem[rdaddress];
   end
`endif

   // Storage array write port. It has no reset, so aclr never disturbs the contents.
   always_ff @(posedge clock) begin
      if (wr_fire) begin
         mem[wraddress] <= data;
      end
   end

   // Registered read port. aclr clears it at once and holds it at zero.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         q <= '0;
      end else begin
         q <= rd_next;
      end
   end

endmodule

// File: tb/tb_ram_port.sv
// tb_ram_port: directed scoreboard bench for ram_port (16 x 8).
// The stimulus pushes one scoreboard entry per clock cycle it drives. The
// monitor pops one entry after each rising edge and compares q when the
// entry is marked as checked.
module tb_ram_port;

   logic       clock;
   logic       aclr;
   logic [7:0] data;
   logic [3:0] wraddress;
   logic       wren;
   logic [3:0] rdaddress;
   logic [7:0] q;

   int total;
   int bad;

   typedef struct {
      bit         chk;
      logic [7:0] exp;
      string      name;
   } sb_entry_t;

   sb_entry_t  sb[$];
   logic [7:0] model [16];

   ram_port #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
      .clock     (clock),
      .aclr      (aclr),
      .data      (data),
      .wraddress (wraddress),
      .wren      (wren),
      .rdaddress (rdaddress),
      .q         (q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Drive one clock cycle of inputs and queue what q must hold after its rising edge.
   task automatic cycle(input logic clr, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic [3:0] ra,
                        input bit chk, input logic [7:0] exp, input string name);
      sb_entry_t e;
      @(negedge clock);
      aclr      = clr;
      wren      = we;
      wraddress = wa;
      data      = wd;
      rdaddress = ra;
      e.chk  = chk;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      if (we && !clr) model[wa] = wd;
   endtask

   // Monitor: q is sampled just after each rising edge, which is away from the edge.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) compare(e.name, q, e.exp);
         end
      end
   end

   // Watchdog that guarantees the run ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      aclr = 1'b1; wren = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      #2;
      compare("reset_q", q, 8'h00);

      // Load 5A and read it back, then clear q asynchronously.
      cycle(1'b0, 1'b1, 4'd0, 8'h5A, 4'd0, 1'b0, 8'h00, "");
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h5A, "preclr_q");
      @(posedge clock);
      #3;
      aclr = 1'b1;
      #1;
      compare("aclr_async_q", q, 8'h00);
      // A write attempted during the clear is suppressed, and q stays 0.
      cycle(1'b1, 1'b1, 4'd0, 8'hFF, 4'd0, 1'b1, 8'h00, "aclr_hold_q");
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b1, 8'h5A, "aclr_write_blocked");

      // Fill the array with 11,22,...,FF, then 00 at address 15.
      for (int i = 0; i < 15; i++)
         cycle(1'b0, 1'b1, 4'(i), 8'((i + 1) * 8'h11), 4'd0, 1'b0, 8'h00, "");
      cycle(1'b0, 1'b1, 4'd15, 8'h00, 4'd0, 1'b0, 8'h00, "");
      for (int i = 0; i < 15; i++)
         cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'(i), 1'b1, 8'((i + 1) * 8'h11), $sformatf("readback_%0d", i));
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd15, 1'b1, 8'h00, "readback_15");

      // Independent ports.
      cycle(1'b0, 1'b1, 4'd7, 8'h3C, 4'd0, 1'b0, 8'h00, "");
      cycle(1'b0, 1'b1, 4'd3, 8'hA5, 4'd7, 1'b1, 8'h3C, "indep_read7");
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 1'b1, 8'hA5, "indep_read3");

      // Same-address collision.
      cycle(1'b0, 1'b1, 4'd9, 8'h10, 4'd0, 1'b0, 8'h00, "");
`ifdef RAM_PORT_BYPASS_EN
      cycle(1'b0, 1'b1, 4'd9, 8'hEE, 4'd9, 1'b1, 8'hEE, "collide_same_edge");
`else
      cycle(1'b0, 1'b1, 4'd9, 8'hEE, 4'd9, 1'b1, 8'h10, "collide_same_edge");
`endif
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 1'b1, 8'hEE, "collide_next");

      // wren=0 leaves address 5 holding 66 from the fill.
      cycle(1'b0, 1'b0, 4'd5, 8'h77, 4'd5, 1'b1, 8'h66, "wren0_same_edge");
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd5, 1'b1, 8'h66, "wren0_after");

      // Reset retention: refill with a new pattern, pulse aclr, then read everything.
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b1, 4'(i), 8'(8'hC3 ^ (i * 8'h07)), 4'd0, 1'b0, 8'h00, "");
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd4, 1'b1, 8'(8'hC3 ^ 8'h1C), "pre_pulse_q");
      @(posedge clock);
      #3;
      aclr = 1'b1;
      #1;
      compare("pulse_q_zero", q, 8'h00);
      #1;
      aclr = 1'b0;
      #1;
      compare("pulse_q_held", q, 8'h00);
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'(i), 1'b1, model[i], $sformatf("retain_%0d", i));

      // Drain the scoreboard.
      repeat (3) @(negedge clock);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
